// File: rtl/timer_arb_pkg.sv
// timer_arb_pkg: shared types and helpers for the timer arbiter slice.
//   state_t       - FSM state encoding (IDLE, RUN, DONE)
//   N_REQ_DEF     - default requester count
//   CNT_W_DEF     - default counter/length width
//   MAX_REQ       - largest supported requester count
//   onehot_index  - index of the set bit in a one-hot vector (0 if none)
package timer_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned MAX_REQ   = 16;

  function automatic int unsigned onehot_index(input logic [MAX_REQ-1:0] v);
    onehot_index = 0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (v[i]) onehot_index = i;
    end
  endfunction

endpackage

// File: rtl/timer_arbiter_if.sv
// timer_arbiter_if: request/grant bundle between sequencers and the arbiter.
//   req   - per-requester request level
//   len   - packed per-requester terminal counts, slice i = len[i*CNT_W +: CNT_W]
//   grant - one-hot owner of the counter
//   done  - one-cycle completion pulse to the owner
//   busy  - arbiter is in RUN or DONE
//   count - current counter value
// Modports: master (sequencer side), slave (arbiter side).
interface timer_arbiter_if
  import timer_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] len;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [CNT_W-1:0]       count;

  modport master (output req, len, input grant, done, busy, count);
  modport slave  (input req, len, output grant, done, busy, count);
endinterface

// File: rtl/timer_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req        - request vector
//   ptr        - highest-priority index this round
//   winner     - one-hot first set request at or after ptr (wrapping), '0 if none
//   winner_idx - index of winner (0 if none)
module rr_pick
  import timer_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         winner,
  output logic [$clog2(N_REQ)-1:0] winner_idx
);
  localparam int unsigned PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]   j;
  logic               found;
  logic [MAX_REQ-1:0] winner_wide;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    j      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = PTR_W'((32'(ptr) + i) % N_REQ);
      if (!found && req[j]) begin
        winner[j] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    winner_wide             = '0;
    winner_wide[N_REQ-1:0]  = winner;
    winner_idx              = PTR_W'(onehot_index(winner_wide));
  end

endmodule

// File: rtl/timer_arbiter.sv
// timer_arbiter: shares one interval counter among N_REQ requesters in
// round-robin order. The owner's counter runs 0..len, then done pulses.
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - timer_arbiter_if.slave: req/len in, grant/done/busy/count out
// Optional feature: define TIMER_ARB_ABORT_EN to let the owner abort its
// interval by dropping req during RUN (no done, pointer still advances).
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  timer_arbiter_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(N_REQ);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win_idx_q, win_idx_d;
  logic [PTR_W-1:0] ptr_adv;
  logic [N_REQ-1:0] pick_oh;
  logic [PTR_W-1:0] pick_idx;
  logic             abort;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (bus.req),
    .ptr        (ptr_q),
    .winner     (pick_oh),
    .winner_idx (pick_idx)
  );

  // Pointer lands just past the current owner so it has lowest priority next.
  assign ptr_adv = (win_idx_q == PTR_W'(N_REQ - 1)) ? '0 : win_idx_q + 1'b1;

`ifdef TIMER_ARB_ABORT_EN
  assign abort = ~|(bus.req & grant_q);
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done_d    = '0;
    count_d   = count_q;
    len_d     = len_q;
    ptr_d     = ptr_q;
    win_idx_d = win_idx_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        count_d = '0;
        if (|bus.req) begin
          state_d   = RUN;
          grant_d   = pick_oh;
          win_idx_d = pick_idx;
          len_d     = bus.len[32'(pick_idx)*CNT_W +: CNT_W];
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          grant_d = '0;
          count_d = '0;
          ptr_d   = ptr_adv;
        end else if (count_q == len_q) begin
          // Done is produced from the next-state path so it is registered
          // and lines up with the DONE state.
          state_d = DONE;
          grant_d = '0;
          done_d  = grant_q;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        count_d = '0;
        ptr_d   = ptr_adv;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      count_q   <= '0;
      len_q     <= '0;
      ptr_q     <= '0;
      win_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      count_q   <= count_d;
      len_q     <= len_d;
      ptr_q     <= ptr_d;
      win_idx_q <= win_idx_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.count = count_q;
  assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed self-checking bench for timer_arbiter
// (N_REQ=4, CNT_W=8). Expectations follow TIMER_ARB_ABORT_EN if defined.
module tb_timer_arbiter;
  import timer_arb_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  timer_arbiter_if #(.N_REQ(4), .CNT_W(8)) bus ();

  timer_arbiter #(.N_REQ(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] d,
                         input logic b, input logic [7:0] c);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".done"},  32'(bus.done),  32'(d));
    chk({tag, ".busy"},  32'(bus.busy),  32'(b));
    chk({tag, ".count"}, 32'(bus.count), 32'(c));
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0] rr_exp [5];

  initial begin
    checks = 0;
    errors = 0;
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000;
    rr_exp[4] = 4'b0001;
    rst     = 1'b1;
    bus.req = '0;
    bus.len = '0;

    // Reset then idle
    step();
    chk_all("in_reset", 4'b0000, 4'b0000, 1'b0, 8'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all("idle", 4'b0000, 4'b0000, 1'b0, 8'd0);
    end

    // Single requester, len0=3
    bus.len[0 +: 8] = 8'd3;
    bus.req = 4'b0001;
    for (int i = 0; i <= 3; i++) begin
      step();
      chk_all("single_run", 4'b0001, 4'b0000, 1'b1, 8'(i));
    end
    step();
    chk_all("single_done", 4'b0000, 4'b0001, 1'b1, 8'd3);
    bus.req = '0;
    step();
    chk_all("single_idle", 4'b0000, 4'b0000, 1'b0, 8'd0);

    // Round-robin with all len=0, from a fresh pointer
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.len = '0;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_all("rr_run", rr_exp[k], 4'b0000, 1'b1, 8'd0);
      step();
      chk_all("rr_done", 4'b0000, rr_exp[k], 1'b1, 8'd0);
      if (k == 4) bus.req = '0;
      step();
      chk_all("rr_idle", 4'b0000, 4'b0000, 1'b0, 8'd0);
    end

    // len=255 on requester 1: no wrap
    bus.len[8 +: 8] = 8'd255;
    bus.req = 4'b0010;
    for (int i = 0; i <= 255; i++) begin
      step();
      chk("max_count", 32'(bus.count), 32'(i));
      chk("max_grant", 32'(bus.grant), 32'h2);
    end
    step();
    chk_all("max_done", 4'b0000, 4'b0010, 1'b1, 8'd255);
    bus.req = '0;
    step();
    chk_all("max_idle", 4'b0000, 4'b0000, 1'b0, 8'd0);

    // Mid-run reset on requester 1, len1=20
    bus.len[8 +: 8] = 8'd20;
    bus.req = 4'b0010;
    for (int i = 0; i <= 7; i++) step();
    chk_all("mr_pre", 4'b0010, 4'b0000, 1'b1, 8'd7);
    rst = 1'b1;
    #1;
    chk_all("mr_async", 4'b0000, 4'b0000, 1'b0, 8'd0);
    step();
    chk_all("mr_hold", 4'b0000, 4'b0000, 1'b0, 8'd0);
    rst = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      step();
      chk("mr_count", 32'(bus.count), 32'(i));
      chk("mr_grant", 32'(bus.grant), 32'h2);
    end
    step();
    chk_all("mr_done", 4'b0000, 4'b0010, 1'b1, 8'd20);
    bus.req = '0;
    step();

    // Abort: requester 1 drops req at count=4, len1=10
    bus.len[8 +: 8] = 8'd10;
    bus.req = 4'b0010;
    for (int i = 0; i <= 4; i++) step();
    chk_all("ab_pre", 4'b0010, 4'b0000, 1'b1, 8'd4);
    bus.req = '0;
    step();
`ifdef TIMER_ARB_ABORT_EN
    chk_all("ab_idle", 4'b0000, 4'b0000, 1'b0, 8'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("ab_nodone", 32'(bus.done), 32'h0);
    end
`else
    chk_all("ab_run", 4'b0010, 4'b0000, 1'b1, 8'd5);
    for (int i = 6; i <= 10; i++) begin
      step();
      chk("ab_count", 32'(bus.count), 32'(i));
    end
    step();
    chk_all("ab_done", 4'b0000, 4'b0010, 1'b1, 8'd10);
    step();
    chk_all("ab_idle", 4'b0000, 4'b0000, 1'b0, 8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
